i2c_slave_regif: RTL and testbench

I2C target (responder) with an 8-bit register-bus back end, the other end of the team's I2C master register-access path. It answers a fixed 7-bit device address, accepts a register pointer byte, then performs auto-incrementing register writes or reads. It lets on-chip register banks be exercised by the existing master in loopback, or by an external controller. Standard/fast mode only, no clock stretching.

---
 rtl/i2c_slave_pkg.sv | 8 +
 rtl/i2c_slave_line_sync.sv | 29 ++
 rtl/i2c_slave_regif.sv | 134 +++++++++++++
 tb/tb_i2c_slave_regif.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state encoding and constants for the I2C register target
package i2c_slave_pkg;
  localparam int CNT_W = 3;
  localparam logic [6:0] DEV_ADDR = 7'h1A;
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, WR, WR_ACK, RD_LOAD, RD, RD_ACK
  } state_t;
endpackage

// File: rtl/i2c_slave_line_sync.sv
// i2c_slave_line_sync: synchronizes SCL/SDA and derives edges and START/STOP
module i2c_slave_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);
  // [0] first stage, [1] synchronized value, [2] history
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign sda_s     = sda_q[1];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target with auto-incrementing 8-bit register bus access
module i2c_slave_regif
  import i2c_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  logic scl_rise, scl_fall, sda_s, start_det, stop_det;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [7:0] sr;
  logic rw, ph;
  logic [7:0] sr_nx;
  assign sr_nx = {sr[6:0], sda_s};
  assign sda_pad_o = 1'b0;
  i2c_slave_line_sync u_sync (
    .clk(clk), .rst(rst), .scl_in(scl_pad_i), .sda_in(sda_pad_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_s(sda_s),
    .start_det(start_det), .stop_det(stop_det)
  );
  // ph marks that the first SCL fall of an ACK slot has been seen
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rw <= 1'b0;
      ph <= 1'b0;
      sda_padoen_o <= 1'b1;
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      busy <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (reg_we) reg_addr <= reg_addr + 8'd1;
      if (start_det) begin
        state <= DEV;
        cnt <= '0;
        ph <= 1'b0;
        sda_padoen_o <= 1'b1;
        busy <= 1'b0;
      end else if (stop_det) begin
        state <= IDLE;
        sda_padoen_o <= 1'b1;
        busy <= 1'b0;
      end else begin
        case (state)
          DEV: if (scl_rise) begin
            sr <= sr_nx;
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              rw <= sda_s;
              ph <= 1'b0;
              busy <= sr[6:0] == DEV_ADDR;
              state <= sr[6:0] == DEV_ADDR ? DEV_ACK : IDLE;
            end
          end
          DEV_ACK: if (scl_fall && !ph) begin
            sda_padoen_o <= 1'b0;
            ph <= 1'b1;
          end else if (ph && rw && scl_rise) begin
            ph <= 1'b0;
            state <= RD_LOAD;
          end else if (ph && !rw && scl_fall) begin
            sda_padoen_o <= 1'b1;
            ph <= 1'b0;
            state <= REG;
          end
          REG: if (scl_rise) begin
            sr <= sr_nx;
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              reg_addr <= sr_nx;
              state <= REG_ACK;
            end
          end
          WR: if (scl_rise) begin
            sr <= sr_nx;
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              reg_wdata <= sr_nx;
              state <= WR_ACK;
            end
          end
          REG_ACK, WR_ACK: if (scl_fall) begin
            ph <= ~ph;
            sda_padoen_o <= ph;
            if (ph) begin
              reg_we <= state == WR_ACK;
              state <= WR;
            end
          end
          RD_LOAD: if (!reg_re) reg_re <= 1'b1;
          else begin
            sr <= reg_rdata;
            state <= RD;
          end
          // ACK (or the master's ACK) is held until the first fall drives bit 7
          RD: if (scl_fall) begin
            sda_padoen_o <= sr[7];
            sr <= {sr[6:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              ph <= 1'b0;
              state <= RD_ACK;
            end
          end
          RD_ACK: if (scl_fall && !ph) begin
            sda_padoen_o <= 1'b1;
            ph <= 1'b1;
          end else if (scl_rise && ph) begin
            ph <= 1'b0;
            if (!sda_s) reg_addr <= reg_addr + 8'd1;
            state <= sda_s ? IDLE : RD_LOAD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: directed I2C master transactions against the register target
module tb_i2c_slave_regif;
  localparam int Q = 10;
  logic clk = 0, rst = 1;
  logic scl_m = 1, sda_m = 1;
  logic sda_pad_o, sda_padoen_o, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] mem [256];
  wire sda_bus = sda_m & (sda_padoen_o | sda_pad_o);
  assign reg_rdata = mem[reg_addr];
  always #5 clk = ~clk;
  i2c_slave_regif dut (
    .clk(clk), .rst(rst), .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );
  int total = 0, bad = 0, viol = 0, drv_n = 0, busy_n = 0;
  logic [7:0] we_a[$], we_d[$], re_a[$];
  logic scl_p = 1, oen_p = 1;
  always @(negedge clk) begin
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_d.push_back(reg_wdata);
    end
    if (reg_re) re_a.push_back(reg_addr);
    if (sda_padoen_o === 1'b0) drv_n++;
    if (busy === 1'b1) busy_n++;
    if (!rst && scl_m && scl_p && sda_padoen_o !== oen_p) viol++;
    scl_p = scl_m;
    oen_p = sda_padoen_o;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic sbit(input logic b);
    w(Q); sda_m = b; w(Q); scl_m = 1; w(2 * Q); scl_m = 0;
  endtask
  task automatic rbit(output logic b);
    w(Q); sda_m = 1; w(Q); scl_m = 1; w(Q);
    @(negedge clk); b = sda_bus;
    w(Q); scl_m = 0;
  endtask
  task automatic sbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) sbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    sbit(ack);
  endtask
  task automatic start();
    sda_m = 1; w(Q); scl_m = 1; w(Q); sda_m = 0; w(Q); scl_m = 0;
  endtask
  task automatic stop();
    w(Q); sda_m = 0; w(Q); scl_m = 1; w(Q); sda_m = 1; w(Q);
  endtask
  initial begin
    logic a;
    logic [7:0] d;
    int wb, rb, dn, bn;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;
    w(4);
    @(negedge clk);
    chk("rst oen", sda_padoen_o, 1);
    chk("rst pad_o", sda_pad_o, 0);
    chk("rst addr", reg_addr, 0);
    chk("rst wdata", reg_wdata, 0);
    chk("rst we/re", {reg_we, reg_re}, 0);
    chk("rst busy", busy, 0);
    rst = 0;
    w(10);
    // single write
    wb = we_a.size();
    start();
    sbyte(8'h34, a); chk("w1 dev ack", a, 0);
    sbyte(8'h05, a); chk("w1 reg ack", a, 0);
    sbyte(8'hA5, a); chk("w1 data ack", a, 0);
    w(2); @(negedge clk);
    chk("w1 busy", busy, 1);
    stop(); w(5); @(negedge clk);
    chk("w1 busy after stop", busy, 0);
    chk("w1 we count", we_a.size() - wb, 1);
    chk("w1 we addr", we_a[wb], 8'h05);
    chk("w1 we data", we_d[wb], 8'hA5);
    // burst write with pointer wrap
    wb = we_a.size();
    start();
    sbyte(8'h34, a); chk("bw dev ack", a, 0);
    sbyte(8'hFE, a); chk("bw reg ack", a, 0);
    sbyte(8'h11, a); chk("bw d0 ack", a, 0);
    sbyte(8'h22, a); chk("bw d1 ack", a, 0);
    sbyte(8'h33, a); chk("bw d2 ack", a, 0);
    stop(); w(5); @(negedge clk);
    chk("bw we count", we_a.size() - wb, 3);
    chk("bw addr0", we_a[wb], 8'hFE);
    chk("bw addr1", we_a[wb + 1], 8'hFF);
    chk("bw addr2", we_a[wb + 2], 8'h00);
    chk("bw data0", we_d[wb], 8'h11);
    chk("bw data2", we_d[wb + 2], 8'h33);
    chk("bw final ptr", reg_addr, 8'h01);
    // random read via repeated start
    wb = we_a.size(); rb = re_a.size();
    start();
    sbyte(8'h34, a); chk("rr dev ack", a, 0);
    sbyte(8'h10, a); chk("rr reg ack", a, 0);
    start();
    sbyte(8'h35, a); chk("rr rd dev ack", a, 0);
    rbyte(d, 1'b1); chk("rr data", d, 8'h3C);
    stop(); w(5); @(negedge clk);
    chk("rr re count", re_a.size() - rb, 1);
    chk("rr re addr", re_a[rb], 8'h10);
    chk("rr no we", we_a.size() - wb, 0);
    chk("rr ptr", reg_addr, 8'h10);
    // sequential read
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03;
    rb = re_a.size();
    start();
    sbyte(8'h34, a); sbyte(8'h10, a); chk("sr reg ack", a, 0);
    start();
    sbyte(8'h35, a); chk("sr rd dev ack", a, 0);
    rbyte(d, 1'b0); chk("sr data0", d, 8'h01);
    rbyte(d, 1'b0); chk("sr data1", d, 8'h02);
    rbyte(d, 1'b1); chk("sr data2", d, 8'h03);
    stop(); w(5); @(negedge clk);
    chk("sr re count", re_a.size() - rb, 3);
    chk("sr re addr0", re_a[rb], 8'h10);
    chk("sr re addr1", re_a[rb + 1], 8'h11);
    chk("sr re addr2", re_a[rb + 2], 8'h12);
    chk("sr ptr", reg_addr, 8'h12);
    // address mismatch
    wb = we_a.size(); rb = re_a.size(); dn = drv_n; bn = busy_n;
    start();
    sbyte(8'h56, a); chk("mm dev nack", a, 1);
    sbyte(8'h00, a); chk("mm data nack", a, 1);
    stop(); w(5);
    chk("mm never drives", drv_n - dn, 0);
    chk("mm never busy", busy_n - bn, 0);
    chk("mm no strobes", (we_a.size() - wb) + (re_a.size() - rb), 0);
    // reset during a driven read bit, then a fresh write
    mem[8'h20] = 8'h0F;
    start();
    sbyte(8'h34, a); sbyte(8'h20, a);
    start();
    sbyte(8'h35, a); chk("rst-rd dev ack", a, 0);
    w(8); @(negedge clk);
    chk("rst-rd bit7 low", sda_padoen_o, 0);
    rst = 1;
    @(negedge clk);
    chk("rst-rd released", sda_padoen_o, 1);
    rst = 0;
    w(Q); scl_m = 1; w(2 * Q);
    wb = we_a.size();
    start();
    sbyte(8'h34, a); chk("rst-wr dev ack", a, 0);
    sbyte(8'h40, a); chk("rst-wr reg ack", a, 0);
    sbyte(8'h77, a); chk("rst-wr data ack", a, 0);
    stop(); w(5); @(negedge clk);
    chk("rst-wr we count", we_a.size() - wb, 1);
    chk("rst-wr we addr", we_a[wb], 8'h40);
    chk("rst-wr we data", we_d[wb], 8'h77);
    // STOP inside a data byte aborts the write
    wb = we_a.size();
    start();
    sbyte(8'h34, a); sbyte(8'h50, a); chk("ab reg ack", a, 0);
    sbit(1); sbit(0); sbit(1); sbit(0);
    stop(); w(5); @(negedge clk);
    chk("ab no we", we_a.size() - wb, 0);
    chk("ab busy", busy, 0);
    chk("ab ptr", reg_addr, 8'h50);
    chk("no drive change while scl high", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
